// File: rtl/qbert_jump_ctrl.sv
// Q*bert jump sequencer: turns one-hot direction requests into timed jump commands,
// tracks the cube position on the 7-row pyramid, visited map, lives and falls.
module qbert_jump_ctrl #(
  parameter int JUMP_CYCLES = 3_000_000,
  parameter int FALL_CYCLES = 50_000_000,
  parameter int LIVES       = 3,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  dir_req,
  output logic [3:0]  qbert_jump,
  output logic [2:0]  cube_row,
  output logic [2:0]  cube_col,
  output logic        landed,
  output logic        fell,
  output logic [27:0] visited,
  output logic [4:0]  visited_cnt,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic        all_done
);

  // state  | meaning
  // IDLE   | waiting for a single-bit direction request
  // JUMP   | qbert_jump held, timer running down to the landing decision
  // LAND   | one-cycle landing pulse, position already updated
  // FALL   | target was off the pyramid, fell held for the fall time
  // OVER   | no lives left, terminal until reset
  // WIN    | all 28 cubes visited, terminal until reset
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_JUMP = 3'd1;
  localparam logic [2:0] S_LAND = 3'd2;
  localparam logic [2:0] S_FALL = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;
  localparam logic [2:0] S_WIN  = 3'd5;

  localparam logic [3:0] DIR_DR = 4'b0001;
  localparam logic [3:0] DIR_DL = 4'b0010;
  localparam logic [3:0] DIR_UR = 4'b0100;
  localparam logic [3:0] DIR_UL = 4'b1000;

  localparam logic [CNT_W-1:0] JUMP_LOAD = CNT_W'(JUMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FALL_LOAD = CNT_W'(FALL_CYCLES - 1);

  logic [2:0]       r_state;
  logic [3:0]       r_dir;
  logic [CNT_W-1:0] r_timer;

  logic              w_req_ok;
  logic              w_tmr_zero;
  logic signed [3:0] w_row_s;
  logic signed [3:0] w_col_s;
  logic signed [3:0] w_tgt_row;
  logic signed [3:0] w_tgt_col;
  logic              w_legal;
  logic [4:0]        w_tgt_idx;
  logic [27:0]       w_tgt_bit;
  logic              w_tgt_new;

  function automatic logic [4:0] cube_index(input logic [2:0] row, input logic [2:0] col);
    logic [4:0] base;
    case (row)
      3'd0:    base = 5'd0;
      3'd1:    base = 5'd1;
      3'd2:    base = 5'd3;
      3'd3:    base = 5'd6;
      3'd4:    base = 5'd10;
      3'd5:    base = 5'd15;
      3'd6:    base = 5'd21;
      default: base = 5'd0;
    endcase
    return base + {2'b00, col};
  endfunction

  assign w_req_ok   = (dir_req != 4'd0) && ((dir_req & (dir_req - 4'd1)) == 4'd0);
  assign w_tmr_zero = (r_timer == '0);
  assign w_row_s    = {1'b0, cube_row};
  assign w_col_s    = {1'b0, cube_col};

  // Signed 4-bit target so stepping up from row/col 0 shows up as negative
  always_comb begin
    w_tgt_row = w_row_s;
    w_tgt_col = w_col_s;
    case (r_dir)
      DIR_DR: begin
        w_tgt_row = w_row_s + 4'sd1;
        w_tgt_col = w_col_s + 4'sd1;
      end
      DIR_DL: begin
        w_tgt_row = w_row_s + 4'sd1;
      end
      DIR_UR: begin
        w_tgt_row = w_row_s - 4'sd1;
      end
      DIR_UL: begin
        w_tgt_row = w_row_s - 4'sd1;
        w_tgt_col = w_col_s - 4'sd1;
      end
      default: begin
        w_tgt_row = w_row_s;
        w_tgt_col = w_col_s;
      end
    endcase
  end

  assign w_legal   = (w_tgt_row >= 4'sd0) && (w_tgt_row <= 4'sd6) &&
                     (w_tgt_col >= 4'sd0) && (w_tgt_col <= w_tgt_row);
  assign w_tgt_idx = cube_index(w_tgt_row[2:0], w_tgt_col[2:0]);
  assign w_tgt_bit = 28'd1 << w_tgt_idx;
  assign w_tgt_new = ((visited & w_tgt_bit) == 28'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dir       <= 4'd0;
      r_timer     <= '0;
      qbert_jump  <= 4'd0;
      cube_row    <= 3'd0;
      cube_col    <= 3'd0;
      landed      <= 1'b0;
      fell        <= 1'b0;
      visited     <= 28'h0000001;
      visited_cnt <= 5'd1;
      lives       <= 3'(LIVES);
      game_over   <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      landed <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_ok) begin
            r_dir      <= dir_req;
            qbert_jump <= dir_req;
            r_timer    <= JUMP_LOAD;
            r_state    <= S_JUMP;
          end
        end
        S_JUMP: begin
          if (w_tmr_zero) begin
            qbert_jump <= 4'd0;
            if (w_legal) begin
              cube_row <= w_tgt_row[2:0];
              cube_col <= w_tgt_col[2:0];
              visited  <= visited | w_tgt_bit;
              if (w_tgt_new) begin
                visited_cnt <= visited_cnt + 5'd1;
              end
              landed  <= 1'b1;
              r_state <= S_LAND;
            end else begin
              fell    <= 1'b1;
              r_timer <= FALL_LOAD;
              r_state <= S_FALL;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_LAND: begin
          if (visited_cnt == 5'd28) begin
            all_done <= 1'b1;
            r_state  <= S_WIN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FALL: begin
          if (w_tmr_zero) begin
            fell  <= 1'b0;
            lives <= lives - 3'd1;
            if (lives == 3'd1) begin
              game_over <= 1'b1;
              r_state   <= S_OVER;
            end else begin
              cube_row <= 3'd0;
              cube_col <= 3'd0;
              r_state  <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_OVER, S_WIN: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Randomized and scripted bench for qbert_jump_ctrl against a behavioural pyramid model.
module tb_qbert_jump_ctrl;

  localparam int JC = 4;
  localparam int FC = 5;
  localparam int LV = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dir_req;
  logic [3:0]  qbert_jump;
  logic [2:0]  cube_row;
  logic [2:0]  cube_col;
  logic        landed;
  logic        fell;
  logic [27:0] visited;
  logic [4:0]  visited_cnt;
  logic [2:0]  lives;
  logic        game_over;
  logic        all_done;

  int n_checks = 0;
  int n_errors = 0;

  int          m_row, m_col, m_lives;
  logic [27:0] m_vis;
  bit          m_over, m_win;

  qbert_jump_ctrl #(.JUMP_CYCLES(JC), .FALL_CYCLES(FC), .LIVES(LV), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .dir_req(dir_req), .qbert_jump(qbert_jump),
    .cube_row(cube_row), .cube_col(cube_col), .landed(landed), .fell(fell),
    .visited(visited), .visited_cnt(visited_cnt), .lives(lives),
    .game_over(game_over), .all_done(all_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_lives = LV;
    m_vis = 28'h1; m_over = 0; m_win = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_jump"}, qbert_jump, 0);
    chk({tag, "_row"}, cube_row, 0);
    chk({tag, "_col"}, cube_col, 0);
    chk({tag, "_vis"}, visited, 28'h1);
    chk({tag, "_vcnt"}, visited_cnt, 1);
    chk({tag, "_lives"}, lives, LV);
    chk({tag, "_flags"}, {landed, fell, game_over, all_done}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Caller is at a negedge with the DUT idle; returns at a negedge.
  task automatic do_jump(input logic [3:0] d, input logic [3:0] inj);
    int dr, dc, nr, nc, k;
    bit legal;
    dir_req = d;
    @(posedge clk);
    #1 dir_req = 4'd0;
    for (int i = 0; i < JC; i++) begin
      @(negedge clk);
      chk("jump_dir", qbert_jump, d);
      chk("jump_row", cube_row, m_row);
      if (i == 0) dir_req = inj;
      if (i == 1) dir_req = 4'd0;
    end
    case (d)
      4'b0001: begin dr = 1;  dc = 1;  end
      4'b0010: begin dr = 1;  dc = 0;  end
      4'b0100: begin dr = -1; dc = 0;  end
      default: begin dr = -1; dc = -1; end
    endcase
    nr = m_row + dr;
    nc = m_col + dc;
    legal = (nr >= 0) && (nr <= 6) && (nc >= 0) && (nc <= nr);
    @(negedge clk);
    if (legal) begin
      m_row = nr; m_col = nc;
      k = nr * (nr + 1) / 2 + nc;
      m_vis[k] = 1'b1;
      chk("land_pulse", landed, 1);
      chk("land_jump", qbert_jump, 0);
      chk("land_row", cube_row, m_row);
      chk("land_col", cube_col, m_col);
      chk("land_vis", visited, m_vis);
      chk("land_vcnt", visited_cnt, $countones(m_vis));
      @(negedge clk);
      chk("post_land", landed, 0);
      if ($countones(m_vis) == 28) m_win = 1;
      chk("all_done", all_done, m_win);
    end else begin
      for (int i = 0; i < FC; i++) begin
        if (i > 0) @(negedge clk);
        chk("fall_fell", fell, 1);
        chk("fall_jump", qbert_jump, 0);
        chk("fall_lives", lives, m_lives);
        chk("fall_row", cube_row, m_row);
      end
      @(negedge clk);
      m_lives--;
      if (m_lives == 0) m_over = 1;
      else begin m_row = 0; m_col = 0; end
      chk("fall_end", fell, 0);
      chk("respawn_lives", lives, m_lives);
      chk("respawn_row", cube_row, m_row);
      chk("respawn_col", cube_col, m_col);
      chk("respawn_vcnt", visited_cnt, $countones(m_vis));
      chk("game_over", game_over, m_over);
    end
  endtask

  task automatic check_ignored(input logic [3:0] d);
    dir_req = d;
    repeat (3) begin
      @(negedge clk);
      chk("ign_jump", qbert_jump, 0);
      chk("ign_row", cube_row, m_row);
    end
    dir_req = 4'd0;
    chk("ign_over", game_over, m_over);
    chk("ign_done", all_done, m_win);
  endtask

  initial begin
    logic [3:0] multi [7];
    multi = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100, 4'b1111};
    reset = 1'b1;
    dir_req = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("rst");

    do_jump(4'b0001, 4'd0);

    do_reset();
    do_jump(4'b1000, 4'd0);

    do_reset();
    repeat (3) do_jump(4'b1000, 4'd0);
    chk("over_lives", lives, 0);
    check_ignored(4'b0010);

    do_reset();
    check_ignored(4'b0011);
    do_jump(4'b0010, 4'b0001);

    do_reset();
    do_jump(4'b0010, 4'd0);
    do_jump(4'b0100, 4'd0);
    chk("revisit_cnt", visited_cnt, 2);

    do_reset();
    for (int c = 0; c <= 6; c++) begin
      while (m_row < 6) do_jump(4'b0010, 4'd0);
      if (c < 6) begin
        while (m_row > c) do_jump(4'b0100, 4'd0);
        do_jump(4'b0001, 4'd0);
      end
    end
    chk("tour_done", all_done, 1);
    chk("tour_cnt", visited_cnt, 28);
    check_ignored(4'b0001);

    do_reset();
    do_jump(4'b0001, 4'd0);
    dir_req = 4'b0010;
    @(posedge clk);
    #1 dir_req = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("midjump");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_jump", qbert_jump, 0);
    end

    do_reset();
    repeat (80) begin
      if (m_over || m_win) begin
        check_ignored(4'($urandom_range(1, 15)));
        do_reset();
      end
      if ($urandom_range(0, 9) == 0)
        check_ignored(multi[$urandom_range(0, 6)]);
      else
        do_jump(4'(1 << $urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qbert_jump_ctrl.md
# qbert_jump_ctrl

Game-logic stage directly upstream of the Q*bert sprite renderer. It turns one-hot direction requests from the touch/keypad decoder into timed `qbert_jump` commands and tracks Q*bert's cube position on the 28-cube pyramid (7 rows). It also keeps the visited-cube map, counts lives and detects falls off the pyramid. `qbert_jump` returns to 4'b0000 between jumps, so the renderer re-anchors on the current cube's `x0`/`y0`.

## Interface
Parameters:
- `JUMP_CYCLES`, 3_000_000: cycles `qbert_jump` is held per jump (≥2).
- `FALL_CYCLES`, 50_000_000: cycles `fell` is held after leaving the pyramid (≥2).
- `LIVES`, 3: lives at reset (1..7).
- `CNT_W`, 32: timer width; must hold max(JUMP_CYCLES, FALL_CYCLES).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `dir_req` in 4: direction request, level or pulse. 0001 DOWN_RIGHT, 0010 DOWN_LEFT, 0100 UP_RIGHT, 1000 UP_LEFT.
- `qbert_jump` out 4: one-hot jump command to the renderer; 0000 when idle.
- `cube_row` out 3: current row, 0 (top) to 6.
- `cube_col` out 3: current column, 0 to `cube_row`.
- `landed` out 1: one-cycle pulse on a successful landing.
- `fell` out 1: high throughout FALL.
- `visited` out 28: bit k set once cube k has been landed on; k = row*(row+1)/2 + col.
- `visited_cnt` out 5: popcount of `visited`.
- `lives` out 3: remaining lives.
- `game_over` out 1: high in OVER.
- `all_done` out 1: high in WIN.

## Operation
- State machine: IDLE, JUMP, LAND, FALL, OVER, WIN.
- IDLE:
  - If `dir_req` has exactly one bit set, latch it into `dir_q`, load timer = JUMP_CYCLES−1 and go to JUMP.
  - Zero or multi-bit requests are ignored.
- JUMP:
  - `qbert_jump` = `dir_q`.
  - Timer decrements each cycle. At timer==0, compute the target:
    - DOWN_RIGHT: (r+1, c+1)
    - DOWN_LEFT: (r+1, c)
    - UP_RIGHT: (r−1, c)
    - UP_LEFT: (r−1, c−1)
  - The target is legal iff 0 ≤ r' ≤ 6 and 0 ≤ c' ≤ r'. Compare in signed 4-bit arithmetic so that r−1 and c−1 below zero are detected.
  - Legal target: go to LAND. Illegal target: load timer = FALL_CYCLES−1 and go to FALL.
- LAND (one cycle):
  - `cube_row`/`cube_col` update to the target.
  - `visited` bit for the target is set; `visited_cnt` increments only if that bit was previously clear.
  - `landed` = 1.
  - Next state is WIN if the updated count equals 28, else IDLE.
- FALL:
  - `fell` = 1, `qbert_jump` = 0000, position unchanged.
  - At timer==0, `lives` decrements. If the result is 0, go to OVER. Otherwise respawn at (0,0) and go to IDLE. `visited` is unchanged on respawn.
- OVER and WIN are terminal. All requests are ignored until `reset`.
- Requests arriving in JUMP, LAND or FALL are dropped, not queued. A level still held on return to IDLE starts a new jump.

## Timing
- Reset values:
  - state IDLE, `qbert_jump` 0000.
  - `cube_row` 0, `cube_col` 0.
  - `visited` 28'h0000001, `visited_cnt` 1.
  - `lives` = LIVES.
  - `landed`, `fell`, `game_over`, `all_done` all 0.
- All outputs are registered.
- Request sampled in IDLE at edge t: `qbert_jump` is valid from t+1 for exactly JUMP_CYCLES cycles.
- LAND cycle: `qbert_jump` = 0000, `landed` = 1, new position visible the same cycle. Back in IDLE the next cycle, so the earliest next jump starts JUMP_CYCLES+2 cycles after the previous one.
- Illegal jump: JUMP_CYCLES cycles of `qbert_jump`, then `fell` high for exactly FALL_CYCLES cycles. `lives` and the respawn position update on the first cycle after `fell` drops.
- Asserting `reset` in any state, mid-jump or mid-fall, forces the reset values immediately. No pending `dir_q` survives.

## Test plan
- Reset, then DOWN_RIGHT pulse with JUMP_CYCLES=4 → `qbert_jump`=0001 for 4 cycles, then `landed` pulse, row=1, col=1, `visited`[2]=1, `visited_cnt`=2.
- From (0,0), UP_LEFT with FALL_CYCLES=5 → 4 jump cycles, then `fell` high for 5 cycles; afterwards `lives`=2, position (0,0), `visited_cnt` unchanged.
- Three illegal jumps from reset with LIVES=3 → `game_over`=1 and `lives`=0; a further DOWN_LEFT request leaves `qbert_jump`=0000.
- `dir_req`=0011, then a DOWN_LEFT pulse during JUMP → neither starts a jump; `cube_row` changes only for the original request.
- Revisit an already-visited cube (DOWN_LEFT then UP_RIGHT) → `visited_cnt` goes 1→2→2.
- Scripted tour landing on all 28 cubes → `all_done`=1 at `visited_cnt`=28. Separately, `reset` asserted mid-JUMP → immediate return to the reset values.
